// File: rtl/serial_word_deserializer.sv
// serial_word_deserializer
//
// Reassembles an LSB-first bit-serial stream into W-bit parallel words and
// hands each completed word to a single-entry valid/ready output register.
// Deserialisation never stalls: if the output register is still occupied
// when a word completes, that word is dropped and the sticky overrun flag
// is raised.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   serial_valid serial_data carries a bit this cycle
//   serial_data  serial bit, LSB of each word first
//   sync         with serial_valid: current bit is bit 0 of a new word
//   out_valid    out_data holds a completed word
//   out_ready    consumer accepts out_data when out_valid & out_ready
//   out_data     assembled word (W bits)
//   overrun      sticky: a completed word was dropped (register full)
//   framing_err  one-cycle pulse: sync arrived mid-word
//   clear_err    clears overrun (a simultaneous new overrun wins)
//   word_count   words loaded into the output register, wraps silently

module serial_word_deserializer #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_valid,
    input  logic             serial_data,
    input  logic             sync,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             overrun,
    output logic             framing_err,
    input  logic             clear_err,
    output logic [CNT_W-1:0] word_count
);

    // Bit counter only ever holds 0..W-1.
    localparam int BW = (W > 2) ? $clog2(W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

    logic [BW-1:0]    r_cnt;
    logic [W-1:0]     r_shreg;
    logic [W-1:0]     r_out_data;
    logic             r_out_valid;
    logic             r_overrun;
    logic             r_framing_err;
    logic [CNT_W-1:0] r_word_count;

    logic [W-1:0]     w_shifted;
    logic             w_complete;
    logic             w_can_load;

    // New bit always enters at the MSB; after W shifts bit 0 sits at the LSB.
    assign w_shifted  = {serial_data, r_shreg[W-1:1]};
    // A sync bit restarts the word at count 1, so with W >= 2 it can never
    // be the completing bit.
    assign w_complete = serial_valid && !sync && (r_cnt == LAST_BIT);
    // The output register is free if empty or being drained this cycle.
    assign w_can_load = !r_out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_shreg       <= '0;
            r_out_data    <= '0;
            r_out_valid   <= 1'b0;
            r_overrun     <= 1'b0;
            r_framing_err <= 1'b0;
            r_word_count  <= '0;
        end else begin
            r_framing_err <= serial_valid && sync && (r_cnt != '0);

            if (serial_valid) begin
                r_shreg <= w_shifted;
                if (sync) begin
                    r_cnt <= BW'(1);
                end else if (w_complete) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + BW'(1);
                end
            end

            if (w_complete && w_can_load) begin
                r_out_data   <= w_shifted;
                r_out_valid  <= 1'b1;
                r_word_count <= r_word_count + CNT_W'(1);
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            // Set has priority over clear.
            if (w_complete && !w_can_load) begin
                r_overrun <= 1'b1;
            end else if (clear_err) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign overrun     = r_overrun;
    assign framing_err = r_framing_err;
    assign word_count  = r_word_count;

endmodule

// File: doc/serial_word_deserializer.md
Name: serial_word_deserializer

Overview:
Receive-end companion for the bit-serial arithmetic blocks. It takes an LSB-first bit-serial result stream, such as the sum output of a serial adder, and reassembles it into W-bit parallel words. Completed words are delivered over a single-entry valid/ready output register. The block reports overruns, framing errors and a delivered-word count.

Parameters:
W, 8, word width in bits; legal range 2..32.
CNT_W, 16, width of the delivered-word counter.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
serial_valid  input  1  serial_data carries a bit this cycle.
serial_data  input  1  serial bit, LSB of each word first.
sync  input  1  sampled only with serial_valid; marks the current bit as bit 0 of a new word.
out_valid  output  1  out_data holds a completed word.
out_ready  input  1  consumer accepts out_data when out_valid & out_ready.
out_data  output  W  assembled word.
overrun  output  1  sticky flag: a completed word was dropped because the output register was full.
framing_err  output  1  one-cycle pulse: sync arrived while a partial word was in progress.
clear_err  input  1  clears overrun.
word_count  output  CNT_W  number of words loaded into the output register; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at posedge):
  - Bit counter, shift register, out_data, out_valid, overrun, framing_err and word_count all go to 0.
  - A partial word in progress is discarded.
  - Inputs in the reset cycle are ignored.
- Bit counter cnt (0..W-1) counts accepted bits of the current word. Cycles with serial_valid=0 change no datapath state.
- Accepted bit, no sync:
  - Shift register shifts right and the new bit enters the MSB: shreg <= {serial_data, shreg[W-1:1]}.
  - cnt increments.
- Accepted bit with sync=1:
  - If cnt != 0, framing_err pulses high in the next cycle and the partial word is discarded.
  - The bit becomes bit 0: shreg gets it at the MSB and cnt <= 1.
  - sync with serial_valid=0 is ignored.
- Word completion: an accepted bit with post-update count equal to W. This includes sync=1 only if W==1, which is excluded by the range, so sync never completes a word.
  - Completed word = {serial_data, shreg[W-1:1]}.
  - cnt returns to 0 and the next bit is bit 0.
- Output load rule at completion:
  - If out_valid==0, or out_valid & out_ready in the same cycle, then out_data <= completed word, out_valid <= 1 and word_count increments.
  - Otherwise the word is dropped and overrun <= 1. word_count does not increment.
- Latency: out_valid rises in the cycle after the W-th bit is accepted.
- Output handshake:
  - A transfer occurs when out_valid & out_ready.
  - out_valid falls the next cycle unless a new word loads in that same cycle; simultaneous accept and load keeps out_valid=1 with the new data.
  - out_data is stable while out_valid=1 and out_ready=0.
- overrun: sticky until clear_err=1 or rst. If clear_err and a new overrun occur in the same cycle, overrun ends at 1 (set wins).
- Deserialisation never stalls. serial_data has no backpressure; backpressure only causes overrun drops.
- Back-to-back words with serial_valid held high: one bit per cycle, one completion every W cycles, no gap required.
- word_count wraps from 2^CNT_W-1 to 0 silently.

Test Plan:
- W=8, out_ready=1, send bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles -> out_valid=1 one cycle after the 8th bit, out_data=0xA5, word_count=1, overrun=0.
- Same word 0xA5 with serial_valid toggling 1/0 every cycle -> identical result, completing 1 cycle after the 8th valid bit; no effect from idle cycles.
- out_ready=0; send 0x3C then 0xFF back-to-back -> out_data holds 0x3C and overrun=1 after the 16th bit. Then raise out_ready for 1 cycle -> out_valid=0 and word_count=1. Then clear_err -> overrun=0.
- Send 3 bits, then a sync bit followed by 7 bits forming 0x81 -> framing_err pulses once and out_data=0x81.
- out_valid=1 holding 0x11 with out_ready asserted in the exact cycle the 8th bit of 0x22 arrives -> next cycle out_valid=1, out_data=0x22, no overrun, word_count incremented twice in total.
- rst asserted after 5 bits, then release and send 0x5A -> out_data=0x5A, word_count=1 with no trace of the partial word.
